// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/countdown timer: FSM encoding,
// count-direction constants and default field moduli.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  localparam int DEF_CLK_HZ   = 100_000_000;
  localparam int DEF_TICK_HZ  = 100;
  localparam int DEF_FRAC_MOD = 100;
  localparam int DEF_SEC_MOD  = 60;
  localparam int DEF_MIN_MOD  = 60;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick enable every DIV enabled cycles.
// The count freezes while disabled and is zeroed by i_sync_clr.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_sync_clr,
  output logic o_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_sync_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_en && !i_sync_clr && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_timer.sv
// min:sec:fraction stopwatch / countdown timer clocked by a tick enable,
// with preset load, lap capture and done/wrap pulses.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int TICK_HZ  = DEF_TICK_HZ,
  parameter int FRAC_MOD = DEF_FRAC_MOD,
  parameter int SEC_MOD  = DEF_SEC_MOD,
  parameter int MIN_MOD  = DEF_MIN_MOD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_run,
  input  logic                        i_clr,
  input  logic                        i_mode,
  input  logic                        i_load,
  input  logic [$clog2(MIN_MOD)-1:0]  i_load_min,
  input  logic [$clog2(SEC_MOD)-1:0]  i_load_sec,
  input  logic [$clog2(FRAC_MOD)-1:0] i_load_frac,
  input  logic                        i_lap,
  output logic [$clog2(MIN_MOD)-1:0]  o_min,
  output logic [$clog2(SEC_MOD)-1:0]  o_sec,
  output logic [$clog2(FRAC_MOD)-1:0] o_frac,
  output logic [$clog2(MIN_MOD)-1:0]  o_lap_min,
  output logic [$clog2(SEC_MOD)-1:0]  o_lap_sec,
  output logic [$clog2(FRAC_MOD)-1:0] o_lap_frac,
  output logic                        o_lap_valid,
  output logic                        o_running,
  output logic                        o_done,
  output logic                        o_wrap,
  output state_t                      o_state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int FW  = $clog2(FRAC_MOD);
  localparam int SW  = $clog2(SEC_MOD);
  localparam int MW  = $clog2(MIN_MOD);
  localparam logic [FW-1:0] FRAC_MAX = FW'(FRAC_MOD - 1);
  localparam logic [SW-1:0] SEC_MAX  = SW'(SEC_MOD - 1);
  localparam logic [MW-1:0] MIN_MAX  = MW'(MIN_MOD - 1);

  if (DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
    $error("stopwatch_timer: CLK_HZ/TICK_HZ must be an exact ratio of at least 2");
  end

  state_t        state_q, state_d;
  logic [MW-1:0] min_q, min_d, lap_min_q, lap_min_d;
  logic [SW-1:0] sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [FW-1:0] frac_q, frac_d, lap_frac_q, lap_frac_d;
  logic          lap_valid_q, lap_valid_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  logic          time_zero;

  // Prescaler is held at zero in IDLE so every fresh start gets a full period.
  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .i_en       (state_q == ST_RUN),
    .i_sync_clr (i_clr || i_load || (state_q == ST_IDLE)),
    .o_tick     (tick)
  );

  assign time_zero = (min_q == '0) && (sec_q == '0) && (frac_q == '0);

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    frac_d      = frac_q;
    lap_min_d   = lap_min_q;
    lap_sec_d   = lap_sec_q;
    lap_frac_d  = lap_frac_q;
    lap_valid_d = lap_valid_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;

    if (i_clr) begin
      state_d     = ST_IDLE;
      min_d       = '0;
      sec_d       = '0;
      frac_d      = '0;
      lap_min_d   = '0;
      lap_sec_d   = '0;
      lap_frac_d  = '0;
      lap_valid_d = 1'b0;
    end else if (i_load) begin
      min_d  = (i_load_min  > MIN_MAX)  ? MIN_MAX  : i_load_min;
      sec_d  = (i_load_sec  > SEC_MAX)  ? SEC_MAX  : i_load_sec;
      frac_d = (i_load_frac > FRAC_MAX) ? FRAC_MAX : i_load_frac;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else begin
      if (tick) begin
        if (i_mode == MODE_UP) begin
          if (frac_q != FRAC_MAX) begin
            frac_d = frac_q + 1'b1;
          end else begin
            frac_d = '0;
            if (sec_q != SEC_MAX) begin
              sec_d = sec_q + 1'b1;
            end else begin
              sec_d = '0;
              if (min_q != MIN_MAX) begin
                min_d = min_q + 1'b1;
              end else begin
                min_d  = '0;
                wrap_d = 1'b1;
              end
            end
          end
        end else if (time_zero) begin
          done_d = 1'b1;
        end else if (frac_q != '0) begin
          frac_d = frac_q - 1'b1;
        end else begin
          frac_d = FRAC_MAX;
          if (sec_q != '0) begin
            sec_d = sec_q - 1'b1;
          end else begin
            sec_d = SEC_MAX;
            min_d = min_q - 1'b1;
          end
        end
      end

      // Lap sees the registered (pre-tick) time.
      if (i_lap) begin
        lap_min_d   = min_q;
        lap_sec_d   = sec_q;
        lap_frac_d  = frac_q;
        lap_valid_d = 1'b1;
      end

      case (state_q)
        ST_IDLE:  if (i_run) state_d = ST_RUN;
        ST_RUN: begin
          if (done_d) begin
            state_d = ST_DONE;
          end else if (!i_run) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (i_run) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      min_q       <= '0;
      sec_q       <= '0;
      frac_q      <= '0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_frac_q  <= '0;
      lap_valid_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      frac_q      <= frac_d;
      lap_min_q   <= lap_min_d;
      lap_sec_q   <= lap_sec_d;
      lap_frac_q  <= lap_frac_d;
      lap_valid_q <= lap_valid_d;
      running_q   <= running_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
    end
  end

  assign o_min       = min_q;
  assign o_sec       = sec_q;
  assign o_frac      = frac_q;
  assign o_lap_min   = lap_min_q;
  assign o_lap_sec   = lap_sec_q;
  assign o_lap_frac  = lap_frac_q;
  assign o_lap_valid = lap_valid_q;
  assign o_running   = running_q;
  assign o_done      = done_q;
  assign o_wrap      = wrap_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: a time-as-one-integer reference model feeds an
// expected queue each clock; a monitor on the falling edge pops and compares.
module tb_stopwatch_timer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int FM      = 100;
  localparam int SM      = 60;
  localparam int MM      = 60;
  localparam int FW      = $clog2(FM);
  localparam int SW      = $clog2(SM);
  localparam int MW      = $clog2(MM);
  localparam int TOTAL   = FM * SM * MM;
  localparam int W       = 2 * (MW + SW + FW) + 6;

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_run, i_clr, i_mode, i_load, i_lap;
  logic [MW-1:0] i_load_min;
  logic [SW-1:0] i_load_sec;
  logic [FW-1:0] i_load_frac;
  logic [MW-1:0] o_min, o_lap_min;
  logic [SW-1:0] o_sec, o_lap_sec;
  logic [FW-1:0] o_frac, o_lap_frac;
  logic          o_lap_valid, o_running, o_done, o_wrap;
  logic [1:0]    dut_state;

  stopwatch_timer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .FRAC_MOD(FM), .SEC_MOD(SM), .MIN_MOD(MM)
  ) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_clr(i_clr), .i_mode(i_mode),
    .i_load(i_load), .i_load_min(i_load_min), .i_load_sec(i_load_sec),
    .i_load_frac(i_load_frac), .i_lap(i_lap), .o_min(o_min), .o_sec(o_sec),
    .o_frac(o_frac), .o_lap_min(o_lap_min), .o_lap_sec(o_lap_sec),
    .o_lap_frac(o_lap_frac), .o_lap_valid(o_lap_valid), .o_running(o_running),
    .o_done(o_done), .o_wrap(o_wrap), .o_state(dut_state)
  );

  // reference model: time held as a single count of fraction units
  int m_st;     // 0 idle, 1 run, 2 pause, 3 done
  int m_ph;     // fraction-period phase, 0..DIV-1
  int m_t;
  int m_lap_t;
  bit m_lap_v, m_done, m_wrap;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  int mon_cyc  = 0;

  logic [W-1:0] act_vec;
  assign act_vec = {o_min, o_sec, o_frac, o_lap_min, o_lap_sec, o_lap_frac,
                    o_lap_valid, o_running, o_done, o_wrap, dut_state};

  function automatic int sat(input int v, input int modulus);
    return (v > modulus - 1) ? modulus - 1 : v;
  endfunction

  function automatic logic [W-1:0] pack_exp();
    return {MW'(m_t / (SM * FM)), SW'((m_t / FM) % SM), FW'(m_t % FM),
            MW'(m_lap_t / (SM * FM)), SW'((m_lap_t / FM) % SM), FW'(m_lap_t % FM),
            m_lap_v, (m_st == 1), m_done, m_wrap, 2'(m_st)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_t = 0; m_lap_t = 0;
    m_lap_v = 1'b0; m_done = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step();
    bit tick;
    int t_old;
    if (!reset) begin
      model_reset();
      return;
    end
    tick   = (m_st == 1) && (m_ph == DIV - 1);
    t_old  = m_t;
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (i_clr) begin
      m_t = 0; m_lap_t = 0; m_lap_v = 1'b0; m_ph = 0; m_st = 0;
    end else if (i_load) begin
      m_t  = sat(int'(i_load_min), MM) * SM * FM + sat(int'(i_load_sec), SM) * FM
           + sat(int'(i_load_frac), FM);
      m_ph = 0;
      if (m_st == 3) m_st = 0;
    end else begin
      if (m_st == 1) m_ph = tick ? 0 : m_ph + 1;
      if (tick) begin
        if (i_mode == 1'b0) begin
          m_wrap = (t_old == TOTAL - 1);
          m_t    = (t_old + 1) % TOTAL;
        end else if (t_old == 0) begin
          m_done = 1'b1;
        end else begin
          m_t = t_old - 1;
        end
      end
      if (i_lap) begin
        m_lap_t = t_old;
        m_lap_v = 1'b1;
      end
      case (m_st)
        0: if (i_run) begin m_st = 1; m_ph = 0; end
        1: if (m_done) m_st = 3; else if (!i_run) m_st = 2;
        2: if (i_run) m_st = 1;
        default: ;
      endcase
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(pack_exp());
    #1;
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_clr();
    i_clr = 1'b1;
    cycle();
    i_clr = 1'b0;
  endtask

  task automatic do_load(input int mi, input int s, input int f);
    i_load      = 1'b1;
    i_load_min  = MW'(mi);
    i_load_sec  = SW'(s);
    i_load_frac = FW'(f);
    cycle();
    i_load = 1'b0;
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    check_eq("async_reset_outputs", int'(act_vec != '0), 0);
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = pack_exp();
    run_n(2);
    reset = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    mon_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_vec !== e) begin
        n_fails++;
        $display("FAIL outputs cyc=%0d got=%h want=%h", mon_cyc, act_vec, e);
      end
    end
  end

  initial begin
    model_reset();
    reset = 1'b0;
    i_run = 1'b0; i_clr = 1'b0; i_mode = 1'b0; i_load = 1'b0; i_lap = 1'b0;
    i_load_min = '0; i_load_sec = '0; i_load_frac = '0;
    run_n(3);
    reset = 1'b1;
    run_n(2);

    // long up-count
    i_mode = 1'b0;
    i_run  = 1'b1;
    run_n(1000);
    i_run = 1'b0;
    run_n(3);

    // wrap from maximum
    do_clr();
    do_load(59, 59, 99);
    i_run = 1'b1;
    run_n(11);
    check_eq("wrap_pulse", int'(o_wrap), 1);
    check_eq("wrap_time", int'(o_min) + int'(o_sec) + int'(o_frac), 0);
    run_n(1);
    check_eq("wrap_one_cycle", int'(o_wrap), 0);
    run_n(3);
    i_run = 1'b0;
    run_n(2);

    // countdown to done, then reload out of DONE
    do_clr();
    i_mode = 1'b1;
    do_load(0, 0, 2);
    i_run = 1'b1;
    run_n(31);
    check_eq("done_pulse", int'(o_done), 1);
    check_eq("done_state", int'(dut_state), 3);
    run_n(40);
    do_load(0, 0, 5);
    run_n(70);
    i_run = 1'b0;
    do_clr();

    // pause keeps prescaler phase
    i_mode = 1'b0;
    i_run  = 1'b1;
    run_n(35);
    i_run = 1'b0;
    run_n(50);
    i_run = 1'b1;
    run_n(6);
    check_eq("resume_frac", int'(o_frac), 4);
    i_run = 1'b0;
    run_n(2);
    do_clr();

    // lap coincident with a tick
    i_run = 1'b1;
    run_n(80);
    i_lap = 1'b1;
    cycle();
    i_lap = 1'b0;
    check_eq("lap_frac", int'(o_lap_frac), 7);
    check_eq("lap_time_frac", int'(o_frac), 8);
    check_eq("lap_valid", int'(o_lap_valid), 1);
    run_n(3);
    i_run = 1'b0;
    run_n(2);
    do_clr();
    check_eq("clr_lap_valid", int'(o_lap_valid), 0);

    // saturating load, then clr+load+lap together
    do_load(63, 63, 127);
    run_n(2);
    i_clr = 1'b1; i_lap = 1'b1;
    do_load(1, 2, 3);
    i_clr = 1'b0; i_lap = 1'b0;
    run_n(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) i_run = ~i_run;
      if ($urandom_range(0, 99) == 0) i_mode = ~i_mode;
      i_clr       = ($urandom_range(0, 299) == 0);
      i_load      = ($urandom_range(0, 199) == 0);
      i_load_min  = MW'($urandom_range(0, 63));
      i_load_sec  = SW'($urandom_range(0, 63));
      i_load_frac = FW'($urandom_range(0, 127));
      i_lap       = ($urandom_range(0, 19) == 0);
      cycle();
    end
    i_clr = 1'b0; i_load = 1'b0; i_lap = 1'b0;

    // asynchronous reset mid-run
    do_clr();
    i_mode = 1'b0;
    i_run  = 1'b1;
    run_n(27);
    async_reset_check();
    run_n(25);
    i_run = 1'b0;
    run_n(2);

    @(negedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
